// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_prefetch
// Brief    : Fetch PC, credit-limited memory requests, prefetch FIFO, redirect flush
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam int               c_CW    = c_PTR_W + 1;
  localparam logic [c_CW:0]    c_DEPTH = (c_CW + 1)'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [c_CW-1:0]    r_count;
  logic [c_CW-1:0]    r_inflight;
  logic [c_CW-1:0]    r_drop;
  logic               r_started;

  logic [31:0]        r_fifo_data [DEPTH];
  logic [31:0]        r_fifo_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_fifo_rd;
  logic [c_PTR_W-1:0] r_fifo_wr;

  // PCs of accepted requests, consumed in response order (dropped ones too)
  logic [31:0]        r_pcq [DEPTH];
  logic [c_PTR_W-1:0] r_pcq_rd;
  logic [c_PTR_W-1:0] r_pcq_wr;

  logic [c_CW:0]      w_occupied;
  logic               w_accept;
  logic               w_resp;
  logic               w_push;
  logic               w_pop;
  logic [c_CW-1:0]    w_inflight_nxt;
  logic [c_CW-1:0]    w_drop_nxt;
  logic [c_CW-1:0]    w_count_nxt;

  // Issue depends only on registered state so memory ready/valid never loop.
  assign w_occupied    = {1'b0, r_count} + {1'b0, r_inflight};
  assign mem_req_valid = r_started && (w_occupied < c_DEPTH);
  assign mem_req_addr  = r_fetch_pc;

  assign w_accept = mem_req_valid && mem_req_ready;
  assign w_resp   = mem_resp_valid;
  assign w_push   = w_resp && (r_drop == '0) && !redirect_valid;
  assign w_pop    = instr_valid && instr_ready;

  assign instr_valid    = (r_count != '0);
  assign instr_data     = r_fifo_data[r_fifo_rd];
  assign instr_pc       = r_fifo_pc[r_fifo_rd];
  assign instr_pc_plus4 = instr_pc + 32'd4;

  always_comb begin
    w_inflight_nxt = r_inflight + c_CW'(w_accept) - c_CW'(w_resp);
    w_drop_nxt     = r_drop;
    w_count_nxt    = r_count + c_CW'(w_push) - c_CW'(w_pop);
    if (redirect_valid) begin
      w_drop_nxt  = w_inflight_nxt;
      w_count_nxt = '0;
    end else if (w_resp && (r_drop != '0)) begin
      w_drop_nxt = r_drop - c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_started  <= 1'b0;
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else begin
      r_started  <= 1'b1;
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
      r_pcq_wr   <= r_pcq_wr + c_PTR_W'(w_accept);
      r_pcq_rd   <= r_pcq_rd + c_PTR_W'(w_resp);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~32'd3;
        r_fifo_rd  <= '0;
        r_fifo_wr  <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        r_fifo_rd <= r_fifo_rd + c_PTR_W'(w_pop);
        r_fifo_wr <= r_fifo_wr + c_PTR_W'(w_push);
      end
    end
  end

  // Payload storage carries no reset; it is only read behind valid counters.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_fifo_wr] <= mem_resp_data;
      r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
    end
    if (w_accept) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_resp_valid && (r_inflight == '0)));
      assert (w_occupied <= c_DEPTH);
      assert (r_drop <= r_inflight);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_prefetch
// Brief    : Directed scoreboard bench for ifetch_prefetch with in-order memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int lat = 1;
  int cyc = 0;

  logic [31:0] exp_addr [$];
  logic [31:0] exp_pc   [$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend [$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0006;
      32'h0000_0004: return 32'h2009_0004;
      32'h0000_0008: return 32'h0109_5020;
      default:       return 32'h8C00_0000 ^ a;
    endcase
  endfunction

  // Memory: decides responses for the next edge on the falling edge.
  always @(negedge clk) begin
    cyc++;
    mem_resp_valid = 1'b0;
    if (reset) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = memfn(pend[0].addr);
        void'(pend.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{mem_req_addr, cyc + lat});
      end
    end
  end

  // Monitor: every request and instruction handshake is scored in order.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        n_vec++;
        if (exp_addr.size() == 0) begin
          n_bad++;
          $display("FAIL req_addr: got %h, expected no request", mem_req_addr);
        end else begin
          e = exp_addr.pop_front();
          if (mem_req_addr !== e) begin
            n_bad++;
            $display("FAIL req_addr: got %h, expected %h", mem_req_addr, e);
          end
        end
      end
      if (instr_valid && instr_ready) begin
        n_vec++;
        if (exp_pc.size() == 0) begin
          n_bad++;
          $display("FAIL instr: got pc %h data %h, expected no instruction", instr_pc, instr_data);
        end else begin
          e = exp_pc.pop_front();
          if (instr_pc !== e || instr_data !== memfn(e) || instr_pc_plus4 !== e + 32'd4) begin
            n_bad++;
            $display("FAIL instr: got pc %h data %h pc4 %h, expected pc %h data %h pc4 %h",
                     instr_pc, instr_data, instr_pc_plus4, e, memfn(e), e + 32'd4);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_addrs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(start + 32'(4 * i));
  endtask

  task automatic push_pcs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    exp_addr.delete();
    exp_pc.delete();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    exp_addr.delete();
    exp_pc.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_pc.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_vec++;
    if (exp_pc.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d instructions still missing, expected 0", name, exp_pc.size());
    end
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a, input int budget);
    int k;
    k = 0;
    while (!(mem_req_valid && mem_req_addr == a) && k < budget) begin
      tick();
      k++;
    end
    check(name, mem_req_addr, a);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_req_addr", mem_req_addr, RESET_PC);

    // Streaming, latency 1
    lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1;
    reset = 1'b0;
    push_addrs(32'h0, 8 + DEPTH + 1);
    push_pcs(32'h0, 8);
    wait_drain("stream_drain", 60);

    // Back-pressure until full, then drain
    do_reset();
    instr_ready = 1'b0;
    reset = 1'b0;
    push_addrs(32'h0, 4);
    repeat (12) tick();
    check("full_req_valid", 32'(mem_req_valid), 32'h0);
    check("full_instr_valid", 32'(instr_valid), 32'h1);
    check("full_head_pc", instr_pc, 32'h0);
    push_addrs(32'h10, 4 + DEPTH + 1);
    push_pcs(32'h0, 8);
    instr_ready = 1'b1;
    tick();
    check("resume_req_valid", 32'(mem_req_valid), 32'h1);
    check("resume_req_addr", mem_req_addr, 32'h10);
    wait_drain("bp_drain", 60);

    // Redirect with responses outstanding, latency 3
    do_reset();
    lat = 3;
    reset = 1'b0;
    push_addrs(32'h0, 20);
    push_pcs(32'h0, 20);
    wait_addr("lat3_reach_10", 32'h10, 30);
    do_redirect(32'h20);
    check("redir_addr", mem_req_addr, 32'h20);
    push_addrs(32'h20, 6 + DEPTH + 1);
    push_pcs(32'h20, 6);
    wait_drain("redir_drain", 80);

    // Misaligned redirect coinciding with a response, latency 1
    do_reset();
    lat = 1;
    reset = 1'b0;
    push_addrs(32'h0, 20);
    push_pcs(32'h0, 20);
    repeat (6) tick();
    do_redirect(32'h23);
    check("redir23_valid", 32'(mem_req_valid), 32'h1);
    check("redir23_addr", mem_req_addr, 32'h20);
    push_addrs(32'h20, 6 + DEPTH + 1);
    push_pcs(32'h20, 6);
    wait_drain("redir23_drain", 60);

    // Request stall holds address, then redirect across the wrap
    do_reset();
    reset = 1'b0;
    push_addrs(32'h0, 20);
    push_pcs(32'h0, 20);
    wait_addr("stall_reach_14", 32'h14, 30);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(mem_req_valid), 32'h1);
      check("stall_addr", mem_req_addr, 32'h14);
    end
    mem_req_ready = 1'b1;
    tick();
    check("unstall_addr", mem_req_addr, 32'h18);
    do_redirect(32'hFFFF_FFFC);
    check("wrap_addr", mem_req_addr, 32'hFFFF_FFFC);
    push_addrs(32'hFFFF_FFFC, 4 + DEPTH + 1);
    push_pcs(32'hFFFF_FFFC, 4);
    wait_drain("wrap_drain", 60);

    // Reset with a full FIFO
    do_reset();
    instr_ready = 1'b0;
    reset = 1'b0;
    push_addrs(32'h0, 4);
    repeat (12) tick();
    check("pre_rst_instr_valid", 32'(instr_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'h0);
    reset = 1'b0;
    exp_addr.delete();
    exp_pc.delete();
    push_addrs(32'h0, 4 + DEPTH + 1);
    push_pcs(32'h0, 4);
    instr_ready = 1'b1;
    tick();
    check("post_rst_req_valid", 32'(mem_req_valid), 32'h1);
    check("post_rst_req_addr", mem_req_addr, RESET_PC);
    wait_drain("post_rst_drain", 60);

    reset = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction fetch front end placed between the instruction memory port and the decode/control stage of the MIPS core. It owns the fetch PC and issues word-aligned read requests to a memory with variable latency. Returned words are buffered in a small prefetch FIFO and presented to decode through a valid/ready handshake. Branch and jump targets arrive through a redirect input, which flushes buffered and in-flight fetches.

Parameters:
DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus in-flight requests (power of 2, >=2)
RESET_PC, 32'h00000000, first fetch address after reset (word aligned)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  32  byte address of requested word, bits[1:0]=0
mem_resp_valid  input  1  one response word, strictly in request order
mem_resp_data  input  32  instruction word
redirect_valid  input  1  load new fetch PC, flush
redirect_pc  input  32  new fetch target
instr_valid  output  1  FIFO head valid to decode
instr_ready  input  1  decode consumes head
instr_data  output  32  instruction at head
instr_pc  output  32  PC of head instruction
instr_pc_plus4  output  32  instr_pc+4, mod 2^32

Behaviour:
- Single clock (clk); reset synchronous active-high (reset). While reset is high, or on the first cycle after it: mem_req_valid=0, instr_valid=0, fetch_pc=RESET_PC, FIFO empty, inflight=0, drop=0. instr_data/instr_pc/instr_pc_plus4 are don't-care while instr_valid=0.
- The memory shares this reset and discards outstanding requests on reset. Reset mid-operation drops all FIFO and in-flight state with no residual responses.
- Counters:
  - count = FIFO occupancy, 0..DEPTH.
  - inflight = accepted requests not yet responded, including ones marked for drop.
  - drop = number of upcoming responses to discard.
- Issue: mem_req_valid = (count + inflight < DEPTH), computed from registered state only; no combinational path from any input. mem_req_addr = fetch_pc.
- A request is accepted when mem_req_valid && mem_req_ready. On acceptance: inflight+1, fetch_pc+4 (wraps 0xFFFFFFFC -> 0).
- While mem_req_ready=0, addr and valid hold stable.
- Response: on mem_resp_valid, inflight-1.
  - If drop>0: drop-1 and the word is discarded.
  - Otherwise, push {mem_resp_data, pc} into the FIFO. Each entry's PC comes from a parallel PC queue captured at request acceptance.
  - Response with inflight=0 is illegal; assert in simulation.
- Output: instr_valid = (count>0). Head fields come from registered storage; no response-to-output bypass. A response appears at instr_valid at the earliest 1 cycle after mem_resp_valid.
- Pop on instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged. Freed credit is visible to issue the next cycle.
- Redirect (redirect_valid=1), effective at the clock edge:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed (count=0).
  - drop <= inflight after this cycle's accept/response updates, i.e. every request outstanding including one accepted this cycle. A response arriving in the redirect cycle is discarded; it consumes either an existing drop or is simply not pushed.
  - A pop handshake in the redirect cycle completes normally; the consumer owns that instruction.
  - mem_req_valid may be high in the redirect cycle with the old address. If accepted, that request counts toward drop.
  - First request to the target is issued the next cycle, subject to credit (count=0, so inflight<DEPTH).
- Back-to-back redirects: each one recomputes drop from the current inflight; the last redirect wins.
- Invariants:
  - count + inflight <= DEPTH.
  - drop <= inflight.
  - FIFO never overflows, since credit is reserved at issue.

Test Plan:
- Reset, memory returns resp 1 cycle after accept, mem_req_ready=1, instr_ready=1 -> requests 0x0,0x4,0x8...; instr stream pc 0x0,0x4,0x8 with data mem[pc>>2], e.g. 0x20080006,0x20090004; instr_pc_plus4=pc+4.
- instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) accepted, then mem_req_valid=0; instr_valid=1 with instr_pc=0x0 stable. Raise instr_ready -> drain 0x0..0xC in order, issue resumes at 0x10 one cycle after first pop.
- Memory latency 3, two requests (0x8,0xC) in flight, redirect_pc=0x20 -> both responses discarded; next instr_valid shows instr_pc=0x20; no entry with pc 0x8/0xC ever presented.
- redirect_pc=0x23 and a response arriving in the same cycle -> fetch resumes at 0x20; the same-cycle response is not presented.
- mem_req_ready low 3 cycles with mem_req_valid=1, addr 0x14 -> addr held at 0x14 each cycle, fetch_pc unchanged; accept on 4th cycle -> next addr 0x18. Redirect to 0xFFFFFFFC -> addresses 0xFFFFFFFC then 0x0.
- FIFO full (count=4) plus reset asserted for 1 cycle -> next cycle instr_valid=0, mem_req_valid=0; following cycle mem_req_addr=RESET_PC.
